// File: rtl/seg_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : seg_pkg                                                          |
// | Brief    : Seven-segment constants (active-high gfedcba) and bank size.     |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package seg_pkg;

   localparam int NUM_DIGITS = 8;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;

endpackage
`default_nettype wire

// File: rtl/seg_scan8_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : seg_scan8_if                                                     |
// | Brief    : Digit inputs and pin-side outputs of the 8-digit scan driver.    |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
interface seg_scan8_if;
   import seg_pkg::*;

   logic [3:0]            d0;
   logic [3:0]            d1;
   logic [3:0]            d2;
   logic [3:0]            d3;
   logic [3:0]            d4;
   logic [3:0]            d5;
   logic [3:0]            d6;
   logic [3:0]            d7;
   logic [NUM_DIGITS-1:0] dp_mask;
   logic [NUM_DIGITS-1:0] an;
   logic [6:0]            seg;
   logic                  dp;
   logic                  frame_done;

   modport master (
      output d0, d1, d2, d3, d4, d5, d6, d7, dp_mask,
      input  an, seg, dp, frame_done
   );

   modport slave (
      input  d0, d1, d2, d3, d4, d5, d6, d7, dp_mask,
      output an, seg, dp, frame_done
   );

endinterface
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : seg7_decode                                                      |
// | Brief    : 4-bit value to active-high gfedcba pattern; non-BCD shows "-".   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module seg7_decode
   import seg_pkg::*;
(
   input  logic [3:0] i_value,
   output logic [6:0] o_pattern
);

   always_comb begin
      o_pattern = SEG_DASH;
      case (i_value)
         4'd0:    o_pattern = SEG_0;
         4'd1:    o_pattern = SEG_1;
         4'd2:    o_pattern = SEG_2;
         4'd3:    o_pattern = SEG_3;
         4'd4:    o_pattern = SEG_4;
         4'd5:    o_pattern = SEG_5;
         4'd6:    o_pattern = SEG_6;
         4'd7:    o_pattern = SEG_7;
         4'd8:    o_pattern = SEG_8;
         4'd9:    o_pattern = SEG_9;
         default: o_pattern = SEG_DASH;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/seg_scan8.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : seg_scan8                                                        |
// | Brief    : Tear-free time-multiplexed driver for an 8-digit 7-segment bank. |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module seg_scan8
   import seg_pkg::*;
#(
   parameter int CLK_DIV    = 50000,
   parameter int BLANK_CYC  = 4,
   parameter int BLANK_LZ   = 1,
   parameter int ACTIVE_LOW = 1
)
(
   input  logic       clk,
   input  logic       rst,
   seg_scan8_if.slave io
);

   localparam int c_TICK_W = $clog2(CLK_DIV);
   localparam int c_IDX_W  = $clog2(NUM_DIGITS);

   // Inactive pin levels; XOR with these applies the output polarity.
   localparam logic [NUM_DIGITS-1:0] c_AN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [6:0]            c_SEG_OFF = (ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic                  c_DP_OFF  = (ACTIVE_LOW != 0);

   logic [c_TICK_W-1:0]   r_tick;
   logic [c_IDX_W-1:0]    r_idx;
   logic [3:0]            r_snap [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] r_snap_dp;
   logic                  r_first;
   logic                  r_frame_done;
   logic [NUM_DIGITS-1:0] r_an;
   logic [6:0]            r_seg;
   logic                  r_dp;

   logic [3:0]            w_din [NUM_DIGITS];
   logic                  w_slot_end;
   logic                  w_load;
   logic                  w_blank;
   logic [3:0]            w_digit;
   logic [6:0]            w_pattern;
   logic                  w_lz;
   logic [6:0]            w_seg_on;
   logic [NUM_DIGITS-1:0] w_onehot;

   assign w_din[0] = io.d0;
   assign w_din[1] = io.d1;
   assign w_din[2] = io.d2;
   assign w_din[3] = io.d3;
   assign w_din[4] = io.d4;
   assign w_din[5] = io.d5;
   assign w_din[6] = io.d6;
   assign w_din[7] = io.d7;

   assign w_slot_end = (r_tick == c_TICK_W'(CLK_DIV - 1));
   assign w_blank    = (r_tick >= c_TICK_W'(CLK_DIV - BLANK_CYC));
   // r_first forces a snapshot on the first cycle out of reset.
   assign w_load     = r_first | (w_slot_end & (r_idx == c_IDX_W'(NUM_DIGITS - 1)));

   assign w_digit  = r_snap[r_idx];
   assign w_lz     = (BLANK_LZ != 0) && r_idx[0] && (w_digit == 4'd0);
   assign w_seg_on = w_lz ? 7'h00 : w_pattern;
   assign w_onehot = NUM_DIGITS'(1) << r_idx;

   seg7_decode u_decode (
      .i_value   (w_digit),
      .o_pattern (w_pattern)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick  <= '0;
         r_idx   <= '0;
         r_first <= 1'b1;
      end else begin
         r_tick  <= w_slot_end ? '0 : r_tick + c_TICK_W'(1);
         r_first <= 1'b0;
         if (w_slot_end) begin
            r_idx <= r_idx + c_IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_snap_dp    <= '0;
         r_frame_done <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            r_snap[i] <= 4'd0;
         end
      end else begin
         r_frame_done <= w_load;
         if (w_load) begin
            r_snap_dp <= io.dp_mask;
            for (int i = 0; i < NUM_DIGITS; i++) begin
               r_snap[i] <= w_din[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_an  <= c_AN_OFF;
         r_seg <= c_SEG_OFF;
         r_dp  <= c_DP_OFF;
      end else begin
         r_an  <= (w_blank ? '0 : w_onehot) ^ c_AN_OFF;
         r_seg <= (w_blank ? 7'h00 : w_seg_on) ^ c_SEG_OFF;
         r_dp  <= (w_blank ? 1'b0 : r_snap_dp[r_idx]) ^ c_DP_OFF;
      end
   end

   assign io.an         = r_an;
   assign io.seg        = r_seg;
   assign io.dp         = r_dp;
   assign io.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan8.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_seg_scan8                                                     |
// | Brief    : Directed + random bench for seg_scan8 against a position model.  |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_seg_scan8;

   localparam int CLK_DIV   = 4;
   localparam int BLANK_CYC = 1;
   localparam int FRAME     = 8 * CLK_DIV;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0] dig [8];
   logic [7:0] dpm;

   seg_scan8_if bus ();

   assign bus.d0      = dig[0];
   assign bus.d1      = dig[1];
   assign bus.d2      = dig[2];
   assign bus.d3      = dig[3];
   assign bus.d4      = dig[4];
   assign bus.d5      = dig[5];
   assign bus.d6      = dig[6];
   assign bus.d7      = dig[7];
   assign bus.dp_mask = dpm;

   seg_scan8 #(
      .CLK_DIV    (CLK_DIV),
      .BLANK_CYC  (BLANK_CYC),
      .BLANK_LZ   (1),
      .ACTIVE_LOW (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus.slave)
   );

   int         checks   = 0;
   int         failures = 0;
   int         j        = 0;   // scan position of the DUT state since reset release
   logic [3:0] msnap [8];
   logic [7:0] mdp;
   logic [6:0] seen_seg [8];
   logic       seen_dp  [8];

   function automatic logic [6:0] dec(input logic [3:0] v);
      case (v)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   function automatic int cur_idx();
      return (j / CLK_DIV) % 8;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp_v);
      end
   endtask

   // One clock: predict the pins from scan position and the modelled snapshot.
   task automatic step();
      int         p;
      int         tick;
      int         idx;
      logic       load;
      logic [6:0] seg_e;
      @(posedge clk);
      #1;
      if (rst) begin
         j = 0;
         for (int i = 0; i < 8; i++) msnap[i] = 4'd0;
         mdp = 8'h00;
         chk("rst_an", bus.an, 8'hFF);
         chk("rst_seg", {1'b0, bus.seg}, 8'h7F);
         chk("rst_dp", {7'b0, bus.dp}, 8'h01);
         chk("rst_frame_done", {7'b0, bus.frame_done}, 8'h00);
      end else begin
         p    = j;
         j    = j + 1;
         tick = p % CLK_DIV;
         idx  = (p / CLK_DIV) % 8;
         load = (p == 0) || (p % FRAME == FRAME - 1);
         if (tick < CLK_DIV - BLANK_CYC) begin
            seg_e = ((idx % 2 == 1) && (msnap[idx] == 4'd0)) ? 7'h7F : ~dec(msnap[idx]);
            chk("scan_an", bus.an, ~(8'h01 << idx));
            chk("scan_seg", {1'b0, bus.seg}, {1'b0, seg_e});
            chk("scan_dp", {7'b0, bus.dp}, {7'b0, ~mdp[idx]});
            seen_seg[idx] = bus.seg;
            seen_dp[idx]  = bus.dp;
         end else begin
            chk("blank_an", bus.an, 8'hFF);
         end
         chk("frame_done", {7'b0, bus.frame_done}, {7'b0, load});
         if (load) begin
            msnap = dig;
            mdp   = dpm;
         end
      end
      chk("one_anode", ($countones(~bus.an) <= 1) ? 8'd1 : 8'd0, 8'd1);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic wait_idx(input int t);
      for (int k = 0; k < 2 * FRAME && cur_idx() != t; k++) step();
   endtask

   task automatic clear_seen();
      for (int i = 0; i < 8; i++) begin
         seen_seg[i] = 7'hxx;
         seen_dp[i]  = 1'bx;
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) dig[i] = 4'(8 - i);
      dpm = 8'h00;
      clear_seen();

      // reset held three cycles
      rst = 1'b1;
      run(3);
      rst = 1'b0;

      // scan order with d7..d0 = 1..8
      run(FRAME + 8);
      clear_seen();
      run(FRAME);
      chk("order_slot0", {1'b0, seen_seg[0]}, 8'h00);
      chk("order_slot7", {1'b0, seen_seg[7]}, 8'h79);

      // leading-zero blanking on tens position
      dig[1] = 4'd0; dig[0] = 4'd7;
      run(FRAME + 8);
      clear_seen();
      run(FRAME);
      chk("lz_slot1", {1'b0, seen_seg[1]}, 8'h7F);
      chk("lz_slot0", {1'b0, seen_seg[0]}, 8'h78);
      dig[1] = 4'd1; dig[0] = 4'd0;
      run(FRAME + 8);
      clear_seen();
      run(FRAME);
      chk("units0_slot1", {1'b0, seen_seg[1]}, 8'h79);
      chk("units0_slot0", {1'b0, seen_seg[0]}, 8'h40);

      // tear-free: d3 changes mid-frame
      dig[3] = 4'd2;
      run(FRAME + 8);
      wait_idx(1);
      dig[3] = 4'd9;
      clear_seen();
      run(12);
      chk("tear_old", {1'b0, seen_seg[3]}, 8'h24);
      run(FRAME);
      chk("tear_new", {1'b0, seen_seg[3]}, 8'h10);

      // illegal BCD and decimal point
      dig[4] = 4'hC; dpm = 8'h10;
      run(FRAME + 8);
      clear_seen();
      run(FRAME);
      chk("illegal_seg", {1'b0, seen_seg[4]}, 8'h3F);
      chk("dp_on", {7'b0, seen_dp[4]}, 8'h00);
      chk("dp_off", {7'b0, seen_dp[0]}, 8'h01);

      // reset in the middle of slot 5
      wait_idx(5);
      run(2);
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      run(FRAME + 8);

      // randomized digits, masks and reset pulses
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 7) == 0) dig[$urandom_range(0, 7)] = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) dpm = 8'($urandom);
         if ($urandom_range(0, 199) == 0) rst = 1'b1;
         step();
         rst = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
